// File: rtl/hgcal_input_quantizer.sv
// -----------------------------------------------------------------------------
// hgcal_input_quantizer
//
// Front end of the hgcal_tanh0 LogicNets network. One frame of NUM_INPUTS
// signed trigger-cell words arrives one word per beat on a valid/ready stream.
// Each word is compared against three programmable thresholds to give a 2-bit
// code. The code is written straight into its slot of a flat pack buffer,
// which layer0 slices as its M0 inputs. A complete frame is held with
// valid/ready toward layer0. Frames that are too short or too long are dropped
// and counted.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset; release is expected to be
//              synchronous to clk
//   s_valid    input word valid
//   s_ready    input word ready (registered; low only while a frame is held)
//   s_data     signed trigger-cell word (IN_WIDTH bits)
//   s_last     marks the final word of a frame
//   m_valid    packed vector valid toward layer0
//   m_ready    layer0 accepts the packed vector
//   m_data     packed codes; word i occupies bits [2i+1:2i]
//   frame_err  single-cycle pulse for each malformed frame
//   drop_cnt   number of dropped frames, saturating at 255
// -----------------------------------------------------------------------------
module hgcal_input_quantizer #(
  parameter int                          NUM_INPUTS = 48,
  parameter int                          IN_WIDTH   = 16,
  parameter int                          OUT_BITS   = 2,
  parameter logic signed [IN_WIDTH-1:0]  T0         = -16'sd256,
  parameter logic signed [IN_WIDTH-1:0]  T1         = 16'sd0,
  parameter logic signed [IN_WIDTH-1:0]  T2         = 16'sd256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic signed [IN_WIDTH-1:0]        s_data,
  input  logic                              s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [NUM_INPUTS*OUT_BITS-1:0]    m_data,
  output logic                              frame_err,
  output logic [7:0]                        drop_cnt
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  // Parameter sanity: the code packing assumes exactly 2 bits per word, and
  // the threshold ladder must be strictly increasing for the codes to be
  // monotonic in the input.
  generate
    if (OUT_BITS != 2) begin : g_bad_out_bits
      $error("hgcal_input_quantizer: OUT_BITS must be 2");
    end
    if (!((T0 < T1) && (T1 < T2))) begin : g_bad_thresholds
      $error("hgcal_input_quantizer: thresholds must satisfy T0 < T1 < T2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // Signed threshold ladder; a word equal to a threshold takes the upper code.
  function automatic logic [1:0] quantise(input logic signed [IN_WIDTH-1:0] x);
    if (x < T0) begin
      return 2'b00;
    end else if (x < T1) begin
      return 2'b01;
    end else if (x < T2) begin
      return 2'b10;
    end
    return 2'b11;
  endfunction

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [IDX_W-1:0]                r_idx;
  logic [IDX_W-1:0]                w_idx_nxt;
  logic                            r_s_ready;
  logic                            r_m_valid;
  logic                            r_frame_err;
  logic [7:0]                      r_drop_cnt;
  logic [NUM_INPUTS*OUT_BITS-1:0]  r_m_data;

  logic                            w_beat;
  logic                            w_err_nxt;
  logic                            w_drop_inc;
  logic [1:0]                      w_code;

  assign w_beat = s_valid && r_s_ready;
  assign w_code = quantise(s_data);

  // Next-state / framing decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_nxt   = 1'b0;
    w_drop_inc  = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_beat) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (s_last) begin
              w_state_nxt = ST_HOLD;
            end else begin
              // Long frame: report once now, swallow the rest in DISCARD.
              w_state_nxt = ST_DISCARD;
              w_err_nxt   = 1'b1;
              w_drop_inc  = 1'b1;
            end
          end else if (s_last) begin
            // Short frame: drop it and start the next frame from slot 0.
            w_idx_nxt  = '0;
            w_err_nxt  = 1'b1;
            w_drop_inc = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      ST_DISCARD: begin
        if (w_beat && s_last) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Control registers. s_ready and m_valid are registered decodes of the
  // next state, so neither depends combinationally on the opposite handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_idx       <= '0;
      r_s_ready   <= 1'b1;
      r_m_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_s_ready   <= (w_state_nxt != ST_HOLD);
      r_m_valid   <= (w_state_nxt == ST_HOLD);
      r_frame_err <= w_err_nxt;
      if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // Pack buffer: the code lands in its slot on the accepting edge. It is
  // written only while filling, so it stays frozen while a frame is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data <= '0;
    end else if ((r_state == ST_FILL) && w_beat) begin
      r_m_data[int'(r_idx)*OUT_BITS +: OUT_BITS] <= w_code;
    end
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign frame_err = r_frame_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
module tb_hgcal_input_quantizer;

  localparam int N   = 48;
  localparam int W   = 16;
  localparam int OB  = 2;
  localparam int T0  = -256;
  localparam int T1  = 0;
  localparam int T2  = 256;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [W-1:0]         s_data = '0;
  logic                 s_last = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [N*OB-1:0]      m_data;
  logic                 frame_err;
  logic [7:0]           drop_cnt;

  hgcal_input_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N*OB-1:0] exp_q[$];
  int  fw[64];
  int  mr_mode  = 1;   // 0: m_ready low, 1: high, 2: random
  bit  gaps     = 1'b0;
  int  err_exp  = 0;
  int  drop_exp = 0;
  int  err_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference quantiser straight from the threshold rule.
  function automatic logic [1:0] code_of(input int x);
    if (x < T0) return 2'd0;
    if (x < T1) return 2'd1;
    if (x < T2) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [N*OB-1:0] pack_words();
    logic [N*OB-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[2*i +: 2] = code_of(fw[i]);
    return v;
  endfunction

  // m_ready driver
  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard
  logic [N*OB-1:0] prev_data;
  bit              prev_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      err_seen  = 0;
    end else begin
      if (frame_err) err_seen++;
      if (m_valid) begin
        check("sready_low_in_hold", 128'(s_ready), 128'(0));
        if (prev_hold) check("hold_stable", 128'(m_data), 128'(prev_data));
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 128'(m_valid), 128'(0));
          end else begin
            check("packed_vector", 128'(m_data), 128'(exp_q.pop_front()));
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_data = m_data;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic send_beat(input int d, input bit last);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = 16'(d);
    s_last  = last;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) check("s_ready_timeout", 128'(s_ready), 128'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) send_beat(fw[i], (i == len - 1));
    if (len == N) begin
      exp_q.push_back(pack_words());
    end else begin
      err_exp++;
      if (drop_exp < 255) drop_exp++;
    end
  endtask

  task automatic fill_random();
    logic signed [15:0] r;
    int edge_vals[9] = '{-257, -256, -255, -1, 0, 1, 255, 256, 257};
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 2))
        0: fw[i] = int'($urandom_range(0, 1200)) - 600;
        1: fw[i] = edge_vals[$urandom_range(0, 8)];
        default: begin
          r = 16'($urandom);
          fw[i] = int'(r);
        end
      endcase
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_m_valid"},   128'(m_valid),   128'(0));
    check({tag, "_s_ready"},   128'(s_ready),   128'(1));
    check({tag, "_frame_err"}, 128'(frame_err), 128'(0));
    check({tag, "_drop_cnt"},  128'(drop_cnt),  128'(0));
    check({tag, "_m_data"},    128'(m_data),    128'(0));
  endtask

  // Called mid-cycle: reset asserts asynchronously, releases on a falling edge.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_q.delete();
    err_exp  = 0;
    drop_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int len;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal ramp frame
    for (int i = 0; i < N; i++) fw[i] = i * 16 - 384;
    send_frame(N);
    check("lat_m_valid", 128'(m_valid), 128'(1));
    check("lat_s_ready", 128'(s_ready), 128'(0));
    check("slot0_code",  128'(m_data[1:0]),   128'(2'b00));
    check("slot24_code", 128'(m_data[49:48]), 128'(2'b10));
    check("slot47_code", 128'(m_data[95:94]), 128'(2'b11));
    @(posedge clk); #1;
    check("after_xfer_m_valid", 128'(m_valid), 128'(0));
    check("after_xfer_s_ready", 128'(s_ready), 128'(1));

    // Threshold edges
    fill_random();
    fw[0] = -257; fw[1] = -256; fw[2] = -1; fw[3] = 0; fw[4] = 255; fw[5] = 256;
    send_frame(N);
    check("edge_codes", 128'(m_data[11:0]), 128'(12'b11_10_10_01_01_00));
    drain();

    // Backpressure with a second frame offered during the hold
    mr_mode = 0;
    @(posedge clk); #2;
    fill_random();
    send_frame(N);
    fill_random();
    fork
      begin
        repeat (20) begin
          @(negedge clk);
          check("bp_m_valid", 128'(m_valid), 128'(1));
          check("bp_s_ready", 128'(s_ready), 128'(0));
        end
        mr_mode = 1;
      end
      send_frame(N);
    join
    drain();

    // Short frame then a good frame
    fill_random();
    send_frame(11);
    repeat (3) @(posedge clk);
    #1;
    check("short_drop_cnt", 128'(drop_cnt), 128'(drop_exp));
    check("short_err_cnt",  128'(err_seen), 128'(err_exp));
    fill_random();
    send_frame(N);
    drain();

    // Long frame then a good frame
    fill_random();
    send_frame(60);
    repeat (3) @(posedge clk);
    #1;
    check("long_drop_cnt", 128'(drop_cnt), 128'(drop_exp));
    check("long_err_cnt",  128'(err_seen), 128'(err_exp));
    fill_random();
    send_frame(N);
    drain();

    // Random traffic with gaps and random backpressure
    gaps    = 1'b1;
    mr_mode = 2;
    for (int f = 0; f < 24; f++) begin
      fill_random();
      case ($urandom_range(0, 5))
        0:       len = $urandom_range(1, N - 1);
        1:       len = $urandom_range(N + 1, 64);
        default: len = N;
      endcase
      send_frame(len);
    end
    mr_mode = 1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("rand_drop_cnt", 128'(drop_cnt), 128'(drop_exp));
    check("rand_err_cnt",  128'(err_seen), 128'(err_exp));
    gaps = 1'b0;

    // Reset while beat 30 is being presented
    fill_random();
    for (int i = 0; i < 30; i++) send_beat(fw[i], 1'b0);
    s_valid = 1'b1;
    s_data  = 16'(fw[30]);
    s_last  = 1'b0;
    #2;
    async_reset("rst_midframe");
    fill_random();
    send_frame(N);
    drain();

    // Reset while holding a frame
    mr_mode = 0;
    @(posedge clk); #2;
    fill_random();
    send_frame(N);
    @(negedge clk);
    check("hold_before_rst", 128'(m_valid), 128'(1));
    #1;
    async_reset("rst_hold");
    mr_mode = 1;
    fill_random();
    send_frame(N);
    drain();

    // drop_cnt saturation
    for (int f = 0; f < 260; f++) send_frame(1);
    repeat (3) @(posedge clk);
    #1;
    check("drop_cnt_saturated", 128'(drop_cnt), 128'(8'd255));
    check("sat_err_cnt",        128'(err_seen), 128'(err_exp));

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hgcal_input_quantizer.md
Name: hgcal_input_quantizer
Overview:
- Upstream stage of the hgcal_tanh0 LogicNets network.
- Accepts one frame of NUM_INPUTS signed trigger-cell words, streamed one word per beat over a valid/ready interface.
- Quantises each word to an OUT_BITS code with three programmable thresholds and packs the codes into the flat vector that the layer0 neuron LUTs slice as their M0 inputs.
- Holds the packed vector with valid/ready toward layer0, and detects and drops malformed frames.

Parameters:
NUM_INPUTS, 48, words per frame (trigger cells per module)
IN_WIDTH, 16, signed input word width
OUT_BITS, 2, code width per input; fixed at 2, elaboration error otherwise
T0, -16'sd256, lowest threshold (signed, IN_WIDTH bits)
T1, 16'sd0, middle threshold
T2, 16'sd256, highest threshold; T0 < T1 < T2 required, elaboration error otherwise

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat ready
s_data  in  IN_WIDTH  signed trigger-cell word
s_last  in  1  marks final word of frame
m_valid  out  1  packed vector valid toward layer0
m_ready  in  1  layer0 side accepts vector
m_data  out  NUM_INPUTS*OUT_BITS  packed codes; word i at bits [2i+1:2i]
frame_err  out  1  one-cycle pulse on framing error
drop_cnt  out  8  saturating count of dropped frames

Behaviour:
- Reset (async assert, sync release): state=FILL, idx=0, m_valid=0, m_data=0, frame_err=0, drop_cnt=0, s_ready=1.
- Reset mid-frame or mid-HOLD discards all partial or held data. No output is produced for that frame.
- Beat transfer: s_valid && s_ready on a rising edge. m transfer: m_valid && m_ready.
- Quantisation (signed compare) gives code q:
  - s_data < T0 -> 00
  - T0 <= s_data < T1 -> 01
  - T1 <= s_data < T2 -> 10
  - s_data >= T2 -> 11
  - Equality with a threshold takes the upper code.
- Code is registered directly into slot idx of the pack buffer on the accepting edge. No extra pipeline stage.
- States:
  - FILL: s_ready=1, m_valid=0. On each beat, write slot idx.
    - idx==NUM_INPUTS-1 and s_last=1: idx<=0, go HOLD.
    - idx<NUM_INPUTS-1 and s_last=0: idx<=idx+1.
    - idx<NUM_INPUTS-1 and s_last=1 (short frame): frame_err=1 next cycle, drop_cnt++, idx<=0, stay FILL.
    - idx==NUM_INPUTS-1 and s_last=0 (long frame): frame_err=1 next cycle, drop_cnt++, idx<=0, go DISCARD.
  - DISCARD: s_ready=1, m_valid=0. Beats are consumed and ignored. A beat with s_last=1 goes to FILL.
  - HOLD: s_ready=0, m_valid=1, m_data stable. On m_ready, go FILL with m_valid=0 next cycle.
- m_data is updated only in FILL. Its value is meaningful only while m_valid=1.
- Latency: last accepted beat at edge t -> m_valid=1 after edge t; m_data is complete that cycle.
- Throughput: NUM_INPUTS+1 cycles per frame minimum, assuming m_ready is held high.
- m_valid is never deasserted without a transfer; m_valid does not depend combinationally on m_ready.
- s_ready is a registered function of state only.
- s_valid=0 beats in FILL leave idx unchanged, so gaps are allowed anywhere in a frame.
- drop_cnt saturates at 255 and never wraps.
- Only one frame_err pulse is raised per bad frame. No new pulse is raised while in DISCARD.

Test Plan:
- Nominal frame: 48 beats with s_data=i*16-384, s_last on beat 47, m_ready=1 -> m_valid high the cycle after beat 47 for one cycle; codes per slot match the rule (e.g. slot 0=00, slot 24=10, slot 47=11); s_ready low for exactly that cycle.
- Threshold edges: words -257, -256, -1, 0, 255, 256 in slots 0..5 -> codes 00, 01, 01, 10, 10, 11.
- Backpressure: m_ready=0 for 20 cycles after frame -> m_valid held, m_data stable, s_ready=0 throughout; a second frame offered during hold is not accepted until the cycle after the m transfer.
- Short frame: s_last on beat 10 -> frame_err pulse, drop_cnt=1, no m_valid; next good frame is output correctly.
- Long frame: 60 beats with s_last on beat 59 -> one frame_err, drop_cnt+1, beats 48..59 discarded, FILL resumes; the following good frame is packed correctly.
- Async reset during beat 30 and during HOLD -> outputs go to reset values immediately; a subsequent full frame is packed with no residue.
